ps2_kbd_decoder: RTL
====================

// Module: ps2_kbd_decoder
// PURPOSE
//  Receives the PS/2 keyboard stream emitted by the MiST I/O block (ps2_kbd_clk/ps2_kbd_data) and deframes it into bytes.
//  Decodes set-2 prefixes (E0 extended, F0 release) into single key events for the core keyboard matrix.
//  Sits directly downstream of the I/O block in the clk_sys domain. Reports framing, parity and timeout errors.
// PARAMETERS
//  TIMEOUT  20000  clk_sys cycles allowed between PS/2 falling edges inside a frame; 16-bit counter, legal range 1..65535
// PORTS
//  clk_sys      in   1  system clock; all logic on posedge
//  reset        in   1  synchronous, active-high reset
//  ps2_clk      in   1  PS/2 clock from I/O block; idles high
//  ps2_data     in   1  PS/2 data from I/O block
//  rx_byte      out  8  last correctly received byte, any value
//  rx_valid     out  1  one-cycle strobe: rx_byte updated
//  key_code     out  8  scancode of decoded key event
//  key_ext      out  1  event was prefixed by E0
//  key_release  out  1  event was prefixed by F0
//  key_valid    out  1  one-cycle strobe: key_* updated
//  frame_err    out  1  one-cycle strobe: frame discarded
// BEHAVIOUR
//  Interface: one clock (clk_sys); reset is synchronous and active-high.
//  Reset values: rx_byte=0, key_code=0, key_ext=0, key_release=0, all strobes=0, state IDLE, prefix flags=0, sync FFs=1.
//  Input sync: both inputs pass through 2 FFs. A falling edge is the previous synced clk=1 and the current synced clk=0.
//  Sample: data is sampled from the synced data bit in the same cycle as the falling edge. Frame is 11 bits:
//    start(0), d0..d7 LSB first, odd parity, stop(1).
//  FSM IDLE: on a falling edge with data=0, go to DATA and set bitcnt=0. If data=1, stay IDLE with no error (glitch).
//  FSM DATA: shift in on each falling edge. After the 8th bit go to PARITY.
//  FSM PARITY: latch the parity bit, go to STOP.
//  FSM STOP: on the falling edge, check the frame.
//    Check passes when stop=1 and XOR(d7..d0,parity)=1.
//    Pass: on the next cycle rx_byte<=byte, rx_valid=1, then decode. Return to IDLE.
//    Fail: on the next cycle frame_err=1, ext/rel prefix flags are cleared, nothing else is output. Return to IDLE.
//  Timeout: in DATA/PARITY/STOP a counter resets on each falling edge and increments otherwise.
//    When it reaches TIMEOUT: frame_err=1 for one cycle, go to IDLE, prefix flags cleared.
//    Counter is held at 0 while in IDLE.
//  Decode, same cycle as rx_valid:
//    E0: set ext flag, no key_valid.
//    F0: set rel flag, no key_valid.
//    00,AA,E1,EE,FA,FC,FE,FF: rx_valid only; flags unchanged.
//    Any other byte: key_valid=1, key_code=byte, key_ext=ext flag, key_release=rel flag; then both flags cleared.
//  key_* and rx_byte hold their values between strobes. At most one of {rx_valid, frame_err} is asserted per cycle.
//  Latency: rx_valid/key_valid assert exactly 1 clk_sys after the cycle in which the synced stop-bit falling edge is detected.
//  A frame that arrives while a strobe is asserted is unaffected (strobes are pure outputs, no backpressure).
//  Reset asserted mid-frame: the partial frame is discarded, flags are cleared, and no strobe is issued.
//  First frame after reset deasserts is received normally.
// TESTING
//  T1 frame 0x1C, parity 0, stop 1 -> rx_valid, rx_byte=1C; key_valid, key_code=1C, ext=0, rel=0; exactly one strobe each.
//  T2 F0 then 1C -> F0 gives rx_valid with no key_valid; 1C gives key_valid, key_code=1C, rel=1, ext=0.
//  T3 E0,F0,75 then 1C -> key_code=75, ext=1, rel=1; then key_code=1C, ext=0, rel=0.
//  T4a 1C with parity bit 1 -> frame_err only, no rx_valid.
//  T4b E0, bad frame, 74 -> key_code=74, ext=0.
//  T5 start + 4 data bits, clock idle TIMEOUT cycles -> one frame_err pulse, FSM IDLE. Next good frame 0x29 -> key_code=29.
//  T6 reset 1 cycle after the 5th data edge -> all outputs 0, no strobes. Following frame 0x5A -> key_code=5A.
//  T7 BAT AA, then E1 -> rx_valid each, no key_valid, ext/rel stay 0.
//  T8 back-to-back frames at PS2DIV=100 rate (bit period 202 clk) for 64 random bytes -> byte stream matches, 0 errors.

Source files
------------

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: synchronises the PS/2 clock/data pair, deframes 11-bit frames into
// bytes and folds set-2 E0/F0 prefixes into single key events with extended/release flags.
module ps2_kbd_decoder #(
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q;
    logic                clk_s1_q, clk_s2_q, clk_prev_q;
    logic                data_s1_q, data_s2_q;
    logic [BIT_W-1:0]    bitcnt_q;
    logic [BYTE_W-1:0]   shift_q;
    logic                parity_q;
    logic [CNT_W-1:0]    tmo_q;
    logic                ext_q, rel_q;
    logic [BYTE_W-1:0]   rx_byte_q;
    logic                rx_valid_q;
    logic [BYTE_W-1:0]   key_code_q;
    logic                key_ext_q, key_rel_q;
    logic                key_valid_q;
    logic                frame_err_q;

    logic                ps2_fall;
    logic                frame_ok;
    logic                tmo_hit;

    // Status bytes from the keyboard that carry no key information
    function automatic logic is_ctrl_byte(input logic [BYTE_W-1:0] b);
        logic r;
        case (b)
            8'h00, 8'hAA, 8'hE1, 8'hEE,
            8'hFA, 8'hFC, 8'hFE, 8'hFF: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    assign ps2_fall = clk_prev_q & ~clk_s2_q;
    assign frame_ok = data_s2_q & (^{shift_q, parity_q});
    assign tmo_hit  = (tmo_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_s1_q   <= 1'b1;
            data_s2_q   <= 1'b1;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_rel_q   <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            clk_prev_q  <= clk_s2_q;
            data_s1_q   <= ps2_data;
            data_s2_q   <= data_s1_q;
            rx_valid_q  <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;

            if (state_q == S_IDLE) begin
                tmo_q <= '0;
                // A falling edge with data high is a glitch, not a start bit
                if (ps2_fall && !data_s2_q) begin
                    state_q  <= S_DATA;
                    bitcnt_q <= '0;
                end
            end else if (ps2_fall) begin
                tmo_q <= '0;
                if (state_q == S_DATA) begin
                    shift_q  <= {data_s2_q, shift_q[BYTE_W-1:1]};
                    bitcnt_q <= bitcnt_q + BIT_W'(1);
                    if (bitcnt_q == BIT_W'(BYTE_W - 1)) begin
                        state_q <= S_PARITY;
                    end
                end else if (state_q == S_PARITY) begin
                    parity_q <= data_s2_q;
                    state_q  <= S_STOP;
                end else begin
                    state_q <= S_IDLE;
                    if (frame_ok) begin
                        rx_byte_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                        if (shift_q == 8'hE0) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_q <= 1'b1;
                        end else if (!is_ctrl_byte(shift_q)) begin
                            key_valid_q <= 1'b1;
                            key_code_q  <= shift_q;
                            key_ext_q   <= ext_q;
                            key_rel_q   <= rel_q;
                            ext_q       <= 1'b0;
                            rel_q       <= 1'b0;
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                        ext_q       <= 1'b0;
                        rel_q       <= 1'b0;
                    end
                end
            end else if (tmo_hit) begin
                // Keyboard stalled mid-frame: drop it and any pending prefix
                state_q     <= S_IDLE;
                tmo_q       <= '0;
                frame_err_q <= 1'b1;
                ext_q       <= 1'b0;
                rel_q       <= 1'b0;
            end else begin
                tmo_q <= tmo_q + CNT_W'(1);
            end
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_release = key_rel_q;
    assign key_valid   = key_valid_q;
    assign frame_err   = frame_err_q;

endmodule
